// File: rtl/instr_encoder_pkg.sv
// -----------------------------------------------------------------------------
// instr_encoder_pkg
// Shared types and constants for the RV32I instruction encoder:
//   - imm_fmt_e   : request format selector (R/I/S/B/U/J plus LI pseudo-op)
//   - enc_state_e : output-side sequencing states of the encoder
//   - OPCODE_*    : RV32I base opcodes
//   - fits_signed : two's-complement range helper used for immediate checks
// -----------------------------------------------------------------------------
package instr_encoder_pkg;

  typedef enum logic [2:0] {
    FMT_R  = 3'd0,
    FMT_I  = 3'd1,
    FMT_S  = 3'd2,
    FMT_B  = 3'd3,
    FMT_U  = 3'd4,
    FMT_J  = 3'd5,
    FMT_LI = 3'd6
  } imm_fmt_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HOLD = 2'd1,
    ST_EXP2 = 2'd2
  } enc_state_e;

  localparam logic [6:0] OPCODE_LUI    = 7'b0110111;
  localparam logic [6:0] OPCODE_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPCODE_JAL    = 7'b1101111;
  localparam logic [6:0] OPCODE_JALR   = 7'b1100111;
  localparam logic [6:0] OPCODE_BRANCH = 7'b1100011;
  localparam logic [6:0] OPCODE_LOAD   = 7'b0000011;
  localparam logic [6:0] OPCODE_STORE  = 7'b0100011;
  localparam logic [6:0] OPCODE_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPCODE_OP     = 7'b0110011;

  localparam logic [2:0]  F3_ADDI  = 3'b000;
  localparam logic [31:0] NOP_WORD = 32'h0000_0013;

  // True when val, read as two's complement, is representable in 'bits' bits:
  // every bit from position bits-1 upward must equal the sign bit.
  function automatic logic fits_signed(input logic [31:0] val, input int bits);
    logic ok;
    ok = 1'b1;
    for (int i = 0; i < 32; i++) begin
      if ((i >= (bits - 1)) && (val[i] != val[31])) begin
        ok = 1'b0;
      end else begin
        ok = ok;
      end
    end
    return ok;
  endfunction

endpackage

// File: rtl/instr_encoder_if.sv
// -----------------------------------------------------------------------------
// instr_encoder_if
// Request and output-word buses of instr_encoder.
//   in_*   : request from the sequencer (valid/ready), fields + immediate
//   out_*  : encoded word to the instruction-memory write port (valid/ready)
//   err_cnt: saturating count of emitted words flagged as erroneous
// Modports: slave = the encoder, master = the sequencer/consumer side.
// -----------------------------------------------------------------------------
interface instr_encoder_if #(
  parameter int ADDR_W    = 32,
  parameter int ERR_CNT_W = 8
);
  logic                 in_valid;
  logic                 in_ready;
  logic [2:0]           in_fmt;
  logic [6:0]           in_opcode;
  logic [4:0]           in_rd;
  logic [4:0]           in_rs1;
  logic [4:0]           in_rs2;
  logic [2:0]           in_funct3;
  logic [6:0]           in_funct7;
  logic [31:0]          in_imm;
  logic                 out_valid;
  logic                 out_ready;
  logic [31:0]          out_instr;
  logic [ADDR_W-1:0]    out_addr;
  logic                 out_err;
  logic [ERR_CNT_W-1:0] err_cnt;

  modport slave (
    input  in_valid, in_fmt, in_opcode, in_rd, in_rs1, in_rs2,
           in_funct3, in_funct7, in_imm, out_ready,
    output in_ready, out_valid, out_instr, out_addr, out_err, err_cnt
  );

  modport master (
    output in_valid, in_fmt, in_opcode, in_rd, in_rs1, in_rs2,
           in_funct3, in_funct7, in_imm, out_ready,
    input  in_ready, out_valid, out_instr, out_addr, out_err, err_cnt
  );
endinterface

// File: rtl/instr_encoder_pack.sv
// -----------------------------------------------------------------------------
// instr_encoder_pack
// Combinational packer: register/funct fields + immediate + format -> RV32I
// word, plus an immediate range/alignment error flag. Out-of-range immediates
// still produce a word built from the truncated bits.
// Optional feature macro: INSTR_ENC_LI_EXPAND_EN
//   defined  : FMT_LI expands to ADDI, or LUI (+ follow-up ADDI in instr2 with
//              li_pair=1 when the low 12 bits are non-zero). Never errors.
//   undefined: FMT_LI and unused codes give ADDI x0,x0,0 with err=1.
// Ports: fmt/opcode/rd/rs1/rs2/funct3/funct7/imm in; instr, err, li_pair,
//        instr2 out.
// -----------------------------------------------------------------------------
module instr_encoder_pack
  import instr_encoder_pkg::*;
(
  input  logic [2:0]  fmt,
  input  logic [6:0]  opcode,
  input  logic [4:0]  rd,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [2:0]  funct3,
  input  logic [6:0]  funct7,
  input  logic [31:0] imm,
  output logic [31:0] instr,
  output logic        err,
  output logic        li_pair,
  output logic [31:0] instr2
);

`ifdef INSTR_ENC_LI_EXPAND_EN
  // Upper part rounded up when bit 11 is set, so the sign-extended ADDI lands exactly.
  logic [19:0] li_hi_s;
  assign li_hi_s = imm[31:12] + {19'd0, imm[11]};
`endif

  // Field packing and immediate legality per format.
  always_comb begin
    instr   = NOP_WORD;
    err     = 1'b0;
    li_pair = 1'b0;
    instr2  = NOP_WORD;
    case (imm_fmt_e'(fmt))
      FMT_R: begin
        instr = {funct7, rs2, rs1, funct3, rd, opcode};
        err   = 1'b0;
      end
      FMT_I: begin
        instr = {imm[11:0], rs1, funct3, rd, opcode};
        err   = !fits_signed(imm, 12);
      end
      FMT_S: begin
        instr = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
        err   = !fits_signed(imm, 12);
      end
      FMT_B: begin
        instr = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
        err   = !fits_signed(imm, 13) || imm[0];
      end
      FMT_U: begin
        instr = {imm[31:12], rd, opcode};
        err   = (imm[11:0] != 12'h000);
      end
      FMT_J: begin
        instr = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
        err   = !fits_signed(imm, 21) || imm[0];
      end
      FMT_LI: begin
`ifdef INSTR_ENC_LI_EXPAND_EN
        err = 1'b0;
        if (fits_signed(imm, 12)) begin
          instr = {imm[11:0], 5'd0, F3_ADDI, rd, OPCODE_OP_IMM};
        end else begin
          instr = {li_hi_s, rd, OPCODE_LUI};
          if (imm[11:0] != 12'h000) begin
            li_pair = 1'b1;
            instr2  = {imm[11:0], rd, F3_ADDI, rd, OPCODE_OP_IMM};
          end else begin
            li_pair = 1'b0;
          end
        end
`else
        instr = NOP_WORD;
        err   = 1'b1;
`endif
      end
      default: begin
        instr = NOP_WORD;
        err   = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/instr_encoder.sv
// -----------------------------------------------------------------------------
// instr_encoder
// Registered RV32I encoder between a boot/self-test sequencer and an
// instruction-memory write port. One word per accepted request, one cycle
// latency, full throughput when the consumer is always ready. Each word is
// presented with a running word address (+4 per output handshake, wrapping).
// Optional feature macro: INSTR_ENC_LI_EXPAND_EN (LI pseudo-op expansion into
// LUI+ADDI; the second word is presented from the EXP2 state).
// Ports:
//   clk   : clock
//   rst_n : synchronous active-low reset
//   bus   : instr_encoder_if.slave (in_* request, out_* word, err_cnt)
// Parameters: ADDR_W, BASE_ADDR (address of first word), ERR_CNT_W.
// -----------------------------------------------------------------------------
module instr_encoder
  import instr_encoder_pkg::*;
#(
  parameter int                ADDR_W    = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR = ADDR_W'(32'h0000_0000),
  parameter int                ERR_CNT_W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  instr_encoder_if.slave bus
);

  localparam logic [ERR_CNT_W-1:0] ERR_CNT_MAX = {ERR_CNT_W{1'b1}};

  enc_state_e           state_r;
  logic                 out_valid_r;
  logic [31:0]          out_instr_r;
  logic                 out_err_r;
  logic [ADDR_W-1:0]    out_addr_r;
  logic [ERR_CNT_W-1:0] err_cnt_r;
  // Second word of an LI pair waiting behind the LUI currently presented.
  logic                 pend_r;
  logic [31:0]          pend_word_r;

  logic [31:0] pack_instr_s;
  logic        pack_err_s;
  logic        pack_li_pair_s;
  logic [31:0] pack_instr2_s;
  logic        in_ready_s;
  logic        accept_s;
  logic        out_hs_s;

  instr_encoder_pack u_pack (
    .fmt     (bus.in_fmt),
    .opcode  (bus.in_opcode),
    .rd      (bus.in_rd),
    .rs1     (bus.in_rs1),
    .rs2     (bus.in_rs2),
    .funct3  (bus.in_funct3),
    .funct7  (bus.in_funct7),
    .imm     (bus.in_imm),
    .instr   (pack_instr_s),
    .err     (pack_err_s),
    .li_pair (pack_li_pair_s),
    .instr2  (pack_instr2_s)
  );

  // No new request while an LI pair is still draining: the request would be
  // accepted with nowhere to hold it.
  assign in_ready_s = (state_r != ST_EXP2) && !pend_r && (!out_valid_r || bus.out_ready);
  assign accept_s   = bus.in_valid && in_ready_s;
  assign out_hs_s   = out_valid_r && bus.out_ready;

  assign bus.in_ready  = in_ready_s;
  assign bus.out_valid = out_valid_r;
  assign bus.out_instr = out_instr_r;
  assign bus.out_addr  = out_addr_r;
  assign bus.out_err   = out_err_r;
  assign bus.err_cnt   = err_cnt_r;

  // Sequencing FSM, output word register, address and error counters.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r     <= ST_IDLE;
      out_valid_r <= 1'b0;
      out_instr_r <= 32'h0000_0000;
      out_err_r   <= 1'b0;
      out_addr_r  <= BASE_ADDR;
      err_cnt_r   <= {ERR_CNT_W{1'b0}};
      pend_r      <= 1'b0;
      pend_word_r <= 32'h0000_0000;
    end else begin
      if (out_hs_s) begin
        out_addr_r <= out_addr_r + ADDR_W'(4);
        if (out_err_r && (err_cnt_r != ERR_CNT_MAX)) begin
          err_cnt_r <= err_cnt_r + ERR_CNT_W'(1);
        end else begin
          err_cnt_r <= err_cnt_r;
        end
      end else begin
        out_addr_r <= out_addr_r;
        err_cnt_r  <= err_cnt_r;
      end

      case (state_r)
        ST_IDLE: begin
          if (accept_s) begin
            state_r     <= ST_HOLD;
            out_valid_r <= 1'b1;
            out_instr_r <= pack_instr_s;
            out_err_r   <= pack_err_s;
            pend_r      <= pack_li_pair_s;
            pend_word_r <= pack_instr2_s;
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_HOLD: begin
          if (out_hs_s && pend_r) begin
            // LUI half consumed: present the follow-up ADDI.
            state_r     <= ST_EXP2;
            out_instr_r <= pend_word_r;
            out_err_r   <= 1'b0;
            pend_r      <= 1'b0;
          end else if (out_hs_s && accept_s) begin
            state_r     <= ST_HOLD;
            out_instr_r <= pack_instr_s;
            out_err_r   <= pack_err_s;
            pend_r      <= pack_li_pair_s;
            pend_word_r <= pack_instr2_s;
          end else if (out_hs_s) begin
            state_r     <= ST_IDLE;
            out_valid_r <= 1'b0;
            out_err_r   <= 1'b0;
          end else begin
            state_r <= ST_HOLD;
          end
        end
        ST_EXP2: begin
          // in_ready is low here, so a handshake can only end the pair.
          if (out_hs_s) begin
            state_r     <= ST_IDLE;
            out_valid_r <= 1'b0;
            out_err_r   <= 1'b0;
          end else begin
            state_r <= ST_EXP2;
          end
        end
        default: begin
          state_r     <= ST_IDLE;
          out_valid_r <= 1'b0;
          out_err_r   <= 1'b0;
          pend_r      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instr_encoder.sv
// -----------------------------------------------------------------------------
// tb_instr_encoder
// Directed bench for instr_encoder. A queue-based reference model derives the
// expected word stream from the RV32I field layouts, and a per-cycle compare
// process checks it; literal expectations pin the model on key vectors.
// A second encoder with ERR_CNT_W=2 shares the same stimulus for saturation.
// Honours INSTR_ENC_LI_EXPAND_EN the same way as the design.
// -----------------------------------------------------------------------------
module tb_instr_encoder;
  import instr_encoder_pkg::*;

  logic clk;
  logic rst_n;
  int   vectors;
  int   miscompares;
  int   cyc;
  bit   chk_en;

  typedef struct {
    logic [31:0] w;
    bit          e;
  } word_t;

  word_t q[$];
  logic [31:0] m_addr;
  int          m_errs;
  bit          m_busy;

  instr_encoder_if #(.ADDR_W(32), .ERR_CNT_W(8)) bus ();
  instr_encoder_if #(.ADDR_W(32), .ERR_CNT_W(2)) bus2 ();

  instr_encoder #(.ADDR_W(32), .BASE_ADDR(32'h0000_0000), .ERR_CNT_W(8)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  instr_encoder #(.ADDR_W(32), .BASE_ADDR(32'h0000_0000), .ERR_CNT_W(2)) u_dut2 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus2)
  );

  assign bus2.in_valid  = bus.in_valid;
  assign bus2.in_fmt    = bus.in_fmt;
  assign bus2.in_opcode = bus.in_opcode;
  assign bus2.in_rd     = bus.in_rd;
  assign bus2.in_rs1    = bus.in_rs1;
  assign bus2.in_rs2    = bus.in_rs2;
  assign bus2.in_funct3 = bus.in_funct3;
  assign bus2.in_funct7 = bus.in_funct7;
  assign bus2.in_imm    = bus.in_imm;
  assign bus2.out_ready = bus.out_ready;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference encoder: expected word(s) and error flag from the ISA layouts.
  function automatic void ref_encode(input logic [2:0] fmt, input logic [6:0] op7,
                                     input logic [4:0] rd5, input logic [4:0] rs15,
                                     input logic [4:0] rs25, input logic [2:0] f33,
                                     input logic [6:0] f77, input logic [31:0] imm,
                                     output int n, output logic [31:0] w0,
                                     output logic [31:0] w1, output bit e0);
    logic [31:0] op, rd, rs1, rs2, f3, f7, hi;
    int s;
    op = 32'(op7); rd = 32'(rd5); rs1 = 32'(rs15); rs2 = 32'(rs25);
    f3 = 32'(f33); f7 = 32'(f77);
    s  = $signed(imm);
    n = 1; w1 = 32'h0; e0 = 1'b0;
    case (fmt)
      3'd0: w0 = (f7 << 25) | (rs2 << 20) | (rs1 << 15) | (f3 << 12) | (rd << 7) | op;
      3'd1: begin
        w0 = ((imm & 32'hFFF) << 20) | (rs1 << 15) | (f3 << 12) | (rd << 7) | op;
        e0 = (s < -2048) || (s > 2047);
      end
      3'd2: begin
        w0 = (((imm >> 5) & 32'h7F) << 25) | (rs2 << 20) | (rs1 << 15) | (f3 << 12)
           | ((imm & 32'h1F) << 7) | op;
        e0 = (s < -2048) || (s > 2047);
      end
      3'd3: begin
        w0 = (((imm >> 12) & 32'h1) << 31) | (((imm >> 5) & 32'h3F) << 25) | (rs2 << 20)
           | (rs1 << 15) | (f3 << 12) | (((imm >> 1) & 32'hF) << 8)
           | (((imm >> 11) & 32'h1) << 7) | op;
        e0 = (s < -4096) || (s > 4095) || (imm[0] == 1'b1);
      end
      3'd4: begin
        w0 = (imm & 32'hFFFF_F000) | (rd << 7) | op;
        e0 = ((imm & 32'hFFF) != 32'h0);
      end
      3'd5: begin
        w0 = (((imm >> 20) & 32'h1) << 31) | (((imm >> 1) & 32'h3FF) << 21)
           | (((imm >> 11) & 32'h1) << 20) | (((imm >> 12) & 32'hFF) << 12) | (rd << 7) | op;
        e0 = (s < -1048576) || (s > 1048575) || (imm[0] == 1'b1);
      end
`ifdef INSTR_ENC_LI_EXPAND_EN
      3'd6: begin
        if ((s >= -2048) && (s <= 2047)) begin
          w0 = ((imm & 32'hFFF) << 20) | (rd << 7) | 32'h13;
        end else begin
          hi = (imm + 32'h800) & 32'hFFFF_F000;
          w0 = hi | (rd << 7) | 32'h37;
          if ((imm & 32'hFFF) != 32'h0) begin
            n  = 2;
            w1 = ((imm & 32'hFFF) << 20) | (rd << 15) | (rd << 7) | 32'h13;
          end
        end
      end
`endif
      default: begin
        w0 = 32'h0000_0013;
        e0 = 1'b1;
      end
    endcase
  endfunction

  // Reference model state update on each clock edge (pre-edge values).
  always @(posedge clk) begin
    bit hs, acc, exp_rdy;
    int n;
    logic [31:0] w0, w1;
    bit e0;
    if (!rst_n) begin
      q.delete();
      m_addr = 32'h0;
      m_errs = 0;
      m_busy = 1'b0;
    end else begin
      exp_rdy = !m_busy && ((q.size() == 0) || bus.out_ready);
      hs  = (q.size() != 0) && bus.out_ready;
      acc = bus.in_valid && exp_rdy;
      if (hs) begin
        if (q[0].e) m_errs++;
        void'(q.pop_front());
        m_addr = m_addr + 32'd4;
        if (q.size() == 0) m_busy = 1'b0;
      end
      if (acc) begin
        ref_encode(bus.in_fmt, bus.in_opcode, bus.in_rd, bus.in_rs1, bus.in_rs2,
                   bus.in_funct3, bus.in_funct7, bus.in_imm, n, w0, w1, e0);
        q.push_back('{w: w0, e: e0});
        if (n == 2) begin
          q.push_back('{w: w1, e: 1'b0});
          m_busy = 1'b1;
        end
      end
    end
  end

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("out_valid", 32'(bus.out_valid), 32'(q.size() != 0));
      if (q.size() != 0) begin
        chk("out_instr", bus.out_instr, q[0].w);
        chk("out_err", 32'(bus.out_err), 32'(q[0].e));
      end
      chk("out_addr", bus.out_addr, m_addr);
      chk("err_cnt", 32'(bus.err_cnt), (m_errs > 255) ? 32'd255 : 32'(m_errs));
      chk("err_cnt_w2", 32'(bus2.err_cnt), (m_errs > 3) ? 32'd3 : 32'(m_errs));
      chk("in_ready", 32'(bus.in_ready),
          32'(!m_busy && ((q.size() == 0) || bus.out_ready)));
    end
  end

  task automatic sync();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    sync();
    rst_n = 1'b0;
    bus.in_valid = 1'b0;
    sync();
    rst_n = 1'b1;
  endtask

  task automatic idle();
    bus.in_valid = 1'b0;
  endtask

  // Present one request and wait (bounded) until it is accepted.
  task automatic send(input logic [2:0] fmt, input logic [6:0] op, input logic [4:0] rd,
                      input logic [4:0] rs1, input logic [4:0] rs2, input logic [2:0] f3,
                      input logic [6:0] f7, input logic [31:0] imm);
    bit done;
    bus.in_valid  = 1'b1;
    bus.in_fmt    = fmt;
    bus.in_opcode = op;
    bus.in_rd     = rd;
    bus.in_rs1    = rs1;
    bus.in_rs2    = rs2;
    bus.in_funct3 = f3;
    bus.in_funct7 = f7;
    bus.in_imm    = imm;
    done = 1'b0;
    for (int t = 0; t < 20 && !done; t++) begin
      @(negedge clk);
      done = bus.in_ready;
      sync();
    end
    if (!done) begin
      vectors++;
      miscompares++;
      $display("FAIL send_timeout: got no accept expected accept within 20 cycles");
    end
  endtask

  initial begin
    int c0;
    rst_n = 1'b0;
    chk_en = 1'b0;
    vectors = 0;
    miscompares = 0;
    cyc = 0;
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_fmt    = 3'd0;
    bus.in_opcode = 7'd0;
    bus.in_rd     = 5'd0;
    bus.in_rs1    = 5'd0;
    bus.in_rs2    = 5'd0;
    bus.in_funct3 = 3'd0;
    bus.in_funct7 = 7'd0;
    bus.in_imm    = 32'd0;

    do_reset();
    chk_en = 1'b1;
    @(negedge clk);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_out_instr", bus.out_instr, 32'h0);
    chk("rst_out_err", 32'(bus.out_err), 32'd0);
    chk("rst_out_addr", bus.out_addr, 32'h0);
    chk("rst_err_cnt", 32'(bus.err_cnt), 32'd0);
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);

    // ADDI x5,x6,-1
    sync();
    send(FMT_I, 7'h13, 5'd5, 5'd6, 5'd0, 3'd0, 7'd0, 32'hFFFF_FFFF);
    idle();
    @(negedge clk);
    chk("addi_word", bus.out_instr, 32'hFFF3_0293);
    chk("addi_err", 32'(bus.out_err), 32'd0);
    chk("addi_addr", bus.out_addr, 32'h0);

    // Branches: legal, misaligned, out of range
    do_reset();
    send(FMT_B, 7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'd8);
    idle();
    @(negedge clk);
    chk("beq8_word", bus.out_instr, 32'h0020_8463);
    sync();
    send(FMT_B, 7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'd3);
    idle();
    @(negedge clk);
    chk("beq3_err", 32'(bus.out_err), 32'd1);
    sync();
    send(FMT_B, 7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'd4096);
    idle();
    @(negedge clk);
    chk("beq4096_err", 32'(bus.out_err), 32'd1);
    chk("err_cnt_1", 32'(bus.err_cnt), 32'd1);
    sync();
    @(negedge clk);
    chk("err_cnt_2", 32'(bus.err_cnt), 32'd2);

    // JAL, LUI with low bits, plus model-only R/S/I/J vectors
    sync();
    send(FMT_J, 7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2048);
    idle();
    @(negedge clk);
    chk("jal_word", bus.out_instr, 32'h0010_00EF);
    chk("jal_err", 32'(bus.out_err), 32'd0);
    sync();
    send(FMT_U, 7'h37, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'h1234_5001);
    idle();
    @(negedge clk);
    chk("lui_word", bus.out_instr, 32'h1234_50B7);
    chk("lui_err", 32'(bus.out_err), 32'd1);
    sync();
    send(FMT_R, 7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 7'h20, 32'd0);
    send(FMT_S, 7'h23, 5'd0, 5'd1, 5'd2, 3'd2, 7'd0, 32'hFFFF_FFFC);
    send(FMT_I, 7'h13, 5'd4, 5'd4, 5'd0, 3'd0, 7'd0, 32'd2048);
    send(FMT_S, 7'h23, 5'd0, 5'd3, 5'd4, 3'd0, 7'd0, 32'hFFFF_F800);
    send(FMT_J, 7'h6F, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFF0_0000);
    send(FMT_J, 7'h6F, 5'd2, 5'd0, 5'd0, 3'd0, 7'd0, 32'h0010_0000);
    send(FMT_B, 7'h63, 5'd0, 5'd3, 5'd4, 3'd1, 7'd0, 32'hFFFF_F000);
    send(FMT_U, 7'h17, 5'd9, 5'd0, 5'd0, 3'd0, 7'd0, 32'hABCD_E000);
    send(3'd7, 7'h13, 5'd1, 5'd1, 5'd1, 3'd0, 7'd0, 32'd0);
    idle();
    sync();

    // Backpressure: held word stays put, new request not accepted
    bus.out_ready = 1'b0;
    send(FMT_R, 7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'd0);
    bus.in_fmt    = FMT_I;
    bus.in_opcode = 7'h13;
    bus.in_rd     = 5'd7;
    bus.in_rs1    = 5'd0;
    bus.in_imm    = 32'd5;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("bp_in_ready", 32'(bus.in_ready), 32'd0);
      chk("bp_hold_word", bus.out_instr, 32'h0020_81B3);
    end
    sync();
    bus.out_ready = 1'b1;
    send(FMT_I, 7'h13, 5'd7, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5);
    idle();
    @(negedge clk);
    chk("bp_next_word", bus.out_instr, 32'h0050_0393);

    // Ten back-to-back words
    do_reset();
    c0 = cyc;
    for (int k = 0; k < 10; k++) begin
      send(FMT_I, 7'h13, 5'd1, 5'd1, 5'd0, 3'd0, 7'd0, 32'(k));
    end
    chk("burst_cycles", 32'(cyc - c0), 32'd10);
    idle();
    @(negedge clk);
    chk("burst_last_addr", bus.out_addr, 32'd36);
    chk("burst_last_word", bus.out_instr, 32'h0090_8093);

`ifdef INSTR_ENC_LI_EXPAND_EN
    do_reset();
    send(FMT_LI, 7'h00, 5'd10, 5'd0, 5'd0, 3'd0, 7'd0, 32'h1234_5FFF);
    idle();
    @(negedge clk);
    chk("li_lui_word", bus.out_instr, 32'h1234_6537);
    chk("li_lui_addr", bus.out_addr, 32'h0);
    @(negedge clk);
    chk("li_addi_word", bus.out_instr, 32'hFFF5_0513);
    chk("li_addi_addr", bus.out_addr, 32'h4);
    chk("li_exp2_in_ready", 32'(bus.in_ready), 32'd0);
    sync();
    send(FMT_LI, 7'h00, 5'd10, 5'd0, 5'd0, 3'd0, 7'd0, 32'h0000_1000);
    idle();
    @(negedge clk);
    chk("li_single_word", bus.out_instr, 32'h0000_1537);
    sync();
    @(negedge clk);
    chk("li_single_done", 32'(bus.out_valid), 32'd0);
    sync();
    send(FMT_LI, 7'h00, 5'd11, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFF_FF9C);
    send(FMT_LI, 7'h00, 5'd12, 5'd0, 5'd0, 3'd0, 7'd0, 32'h8000_0800);
    idle();
    repeat (4) sync();
    // Reset while the ADDI half is presented
    send(FMT_LI, 7'h00, 5'd10, 5'd0, 5'd0, 3'd0, 7'd0, 32'h1234_5FFF);
    idle();
    @(negedge clk);
    sync();
    rst_n = 1'b0;
    @(negedge clk);
    chk("exp2_in_ready", 32'(bus.in_ready), 32'd0);
    chk("exp2_word", bus.out_instr, 32'hFFF5_0513);
    sync();
    rst_n = 1'b1;
    @(negedge clk);
    chk("exp2_rst_valid", 32'(bus.out_valid), 32'd0);
    chk("exp2_rst_addr", bus.out_addr, 32'h0);
    chk("exp2_rst_err_cnt", 32'(bus.err_cnt), 32'd0);
    sync();
    @(negedge clk);
    chk("exp2_dropped", 32'(bus.out_valid), 32'd0);
`else
    do_reset();
    send(FMT_LI, 7'h00, 5'd10, 5'd0, 5'd0, 3'd0, 7'd0, 32'h1234_5FFF);
    idle();
    @(negedge clk);
    chk("li_off_word", bus.out_instr, 32'h0000_0013);
    chk("li_off_err", 32'(bus.out_err), 32'd1);
`endif

    // Saturation of the 2-bit counter
    do_reset();
    for (int k = 0; k < 5; k++) begin
      send(FMT_U, 7'h37, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd1);
    end
    idle();
    sync();
    @(negedge clk);
    chk("sat_err_cnt_w2", 32'(bus2.err_cnt), 32'd3);
    chk("sat_err_cnt_w8", 32'(bus.err_cnt), 32'd5);

    sync();
    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
